// File: rtl/ysyx_24090012_axi_arbiter.sv
// Two-master / one-slave AXI4 arbiter: IFU (m0, read-only) and LSU (m1, read/write)
// share io_master one whole transaction at a time, with round-robin grants.
module ysyx_24090012_axi_arbiter #(
  parameter int ID_W = 4
) (
  input  logic            clock,
  input  logic            reset,
  // IFU read
  input  logic            m0_arvalid,
  output logic            m0_arready,
  input  logic [31:0]     m0_araddr,
  input  logic [ID_W-1:0] m0_arid,
  input  logic [7:0]      m0_arlen,
  input  logic [2:0]      m0_arsize,
  input  logic [1:0]      m0_arburst,
  output logic            m0_rvalid,
  input  logic            m0_rready,
  output logic [31:0]     m0_rdata,
  output logic [1:0]      m0_rresp,
  output logic [ID_W-1:0] m0_rid,
  output logic            m0_rlast,
  // LSU read
  input  logic            m1_arvalid,
  output logic            m1_arready,
  input  logic [31:0]     m1_araddr,
  input  logic [ID_W-1:0] m1_arid,
  input  logic [7:0]      m1_arlen,
  input  logic [2:0]      m1_arsize,
  input  logic [1:0]      m1_arburst,
  output logic            m1_rvalid,
  input  logic            m1_rready,
  output logic [31:0]     m1_rdata,
  output logic [1:0]      m1_rresp,
  output logic [ID_W-1:0] m1_rid,
  output logic            m1_rlast,
  // LSU write
  input  logic            m1_awvalid,
  output logic            m1_awready,
  input  logic [31:0]     m1_awaddr,
  input  logic [ID_W-1:0] m1_awid,
  input  logic [7:0]      m1_awlen,
  input  logic [2:0]      m1_awsize,
  input  logic [1:0]      m1_awburst,
  input  logic            m1_wvalid,
  output logic            m1_wready,
  input  logic [31:0]     m1_wdata,
  input  logic [3:0]      m1_wstrb,
  input  logic            m1_wlast,
  output logic            m1_bvalid,
  input  logic            m1_bready,
  output logic [1:0]      m1_bresp,
  output logic [ID_W-1:0] m1_bid,
  // shared slave-facing port
  output logic            io_master_arvalid,
  input  logic            io_master_arready,
  output logic [31:0]     io_master_araddr,
  output logic [ID_W-1:0] io_master_arid,
  output logic [7:0]      io_master_arlen,
  output logic [2:0]      io_master_arsize,
  output logic [1:0]      io_master_arburst,
  input  logic            io_master_rvalid,
  output logic            io_master_rready,
  input  logic [31:0]     io_master_rdata,
  input  logic [1:0]      io_master_rresp,
  input  logic [ID_W-1:0] io_master_rid,
  input  logic            io_master_rlast,
  output logic            io_master_awvalid,
  input  logic            io_master_awready,
  output logic [31:0]     io_master_awaddr,
  output logic [ID_W-1:0] io_master_awid,
  output logic [7:0]      io_master_awlen,
  output logic [2:0]      io_master_awsize,
  output logic [1:0]      io_master_awburst,
  output logic            io_master_wvalid,
  input  logic            io_master_wready,
  output logic [31:0]     io_master_wdata,
  output logic [3:0]      io_master_wstrb,
  output logic            io_master_wlast,
  input  logic            io_master_bvalid,
  output logic            io_master_bready,
  input  logic [1:0]      io_master_bresp,
  input  logic [ID_W-1:0] io_master_bid,
  // debug
  output logic [1:0]      arb_state,
  output logic            arb_owner
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  logic   req0, req1, grant;
  logic   rd, wr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign req0 = m0_arvalid;
  assign req1 = m1_arvalid | m1_awvalid;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: if (req0 | req1) begin
        // Tie goes to whoever was not granted last; last resets to 0 so LSU wins first.
        grant   = (req0 & req1) ? ~last_q : req1;
        owner_d = grant;
        last_d  = grant;
        state_d = (grant & m1_awvalid) ? WR : RD;
      end
      RD: if (io_master_rvalid & io_master_rready & io_master_rlast) state_d = IDLE;
      WR: if (io_master_bvalid & io_master_bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rd = (state_q == RD);
  assign wr = (state_q == WR);

  // Read path: owner's AR/R wired straight through, non-owner held off.
  assign io_master_arvalid = rd & (owner_q ? m1_arvalid : m0_arvalid);
  assign io_master_araddr  = owner_q ? m1_araddr  : m0_araddr;
  assign io_master_arid    = owner_q ? m1_arid    : m0_arid;
  assign io_master_arlen   = owner_q ? m1_arlen   : m0_arlen;
  assign io_master_arsize  = owner_q ? m1_arsize  : m0_arsize;
  assign io_master_arburst = owner_q ? m1_arburst : m0_arburst;
  assign io_master_rready  = rd & (owner_q ? m1_rready : m0_rready);

  assign m0_arready = rd & ~owner_q & io_master_arready;
  assign m1_arready = rd &  owner_q & io_master_arready;
  assign m0_rvalid  = rd & ~owner_q & io_master_rvalid;
  assign m1_rvalid  = rd &  owner_q & io_master_rvalid;
  assign m0_rdata   = io_master_rdata;
  assign m0_rresp   = io_master_rresp;
  assign m0_rid     = io_master_rid;
  assign m0_rlast   = io_master_rlast;
  assign m1_rdata   = io_master_rdata;
  assign m1_rresp   = io_master_rresp;
  assign m1_rid     = io_master_rid;
  assign m1_rlast   = io_master_rlast;

  // Write path: only the LSU ever owns WR; AW and W complete independently.
  assign io_master_awvalid = wr & m1_awvalid;
  assign io_master_awaddr  = m1_awaddr;
  assign io_master_awid    = m1_awid;
  assign io_master_awlen   = m1_awlen;
  assign io_master_awsize  = m1_awsize;
  assign io_master_awburst = m1_awburst;
  assign io_master_wvalid  = wr & m1_wvalid;
  assign io_master_wdata   = m1_wdata;
  assign io_master_wstrb   = m1_wstrb;
  assign io_master_wlast   = m1_wlast;
  assign io_master_bready  = wr & m1_bready;

  assign m1_awready = wr & io_master_awready;
  assign m1_wready  = wr & io_master_wready;
  assign m1_bvalid  = wr & io_master_bvalid;
  assign m1_bresp   = io_master_bresp;
  assign m1_bid     = io_master_bid;

  assign arb_state = state_q;
  assign arb_owner = owner_q;

endmodule

// File: tb/tb_ysyx_24090012_axi_arbiter.sv
// Bench for the IFU/LSU AXI arbiter: arbitration table, directed corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_ysyx_24090012_axi_arbiter;
  localparam int ID_W = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
  logic [31:0] m0_araddr, m0_rdata;
  logic [ID_W-1:0] m0_arid, m0_rid;
  logic [7:0] m0_arlen;
  logic [2:0] m0_arsize;
  logic [1:0] m0_arburst, m0_rresp;
  logic m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
  logic [31:0] m1_araddr, m1_rdata;
  logic [ID_W-1:0] m1_arid, m1_rid;
  logic [7:0] m1_arlen;
  logic [2:0] m1_arsize;
  logic [1:0] m1_arburst, m1_rresp;
  logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast, m1_bvalid, m1_bready;
  logic [31:0] m1_awaddr, m1_wdata;
  logic [ID_W-1:0] m1_awid, m1_bid;
  logic [7:0] m1_awlen;
  logic [2:0] m1_awsize;
  logic [1:0] m1_awburst, m1_bresp;
  logic [3:0] m1_wstrb;
  logic io_master_arvalid, io_master_arready, io_master_rvalid, io_master_rready, io_master_rlast;
  logic [31:0] io_master_araddr, io_master_rdata;
  logic [ID_W-1:0] io_master_arid, io_master_rid;
  logic [7:0] io_master_arlen;
  logic [2:0] io_master_arsize;
  logic [1:0] io_master_arburst, io_master_rresp;
  logic io_master_awvalid, io_master_awready, io_master_wvalid, io_master_wready, io_master_wlast;
  logic io_master_bvalid, io_master_bready;
  logic [31:0] io_master_awaddr, io_master_wdata;
  logic [ID_W-1:0] io_master_awid, io_master_bid;
  logic [7:0] io_master_awlen;
  logic [2:0] io_master_awsize;
  logic [1:0] io_master_awburst, io_master_bresp;
  logic [3:0] io_master_wstrb;
  logic [1:0] arb_state;
  logic arb_owner;

  ysyx_24090012_axi_arbiter #(.ID_W(ID_W)) dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rid(m0_rid), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
    .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rid(m1_rid), .m1_rlast(m1_rlast),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid),
    .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_wlast(m1_wlast), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
    .m1_bid(m1_bid),
    .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
    .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
    .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
    .io_master_arburst(io_master_arburst),
    .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready),
    .io_master_rdata(io_master_rdata), .io_master_rresp(io_master_rresp),
    .io_master_rid(io_master_rid), .io_master_rlast(io_master_rlast),
    .io_master_awvalid(io_master_awvalid), .io_master_awready(io_master_awready),
    .io_master_awaddr(io_master_awaddr), .io_master_awid(io_master_awid),
    .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
    .io_master_awburst(io_master_awburst),
    .io_master_wvalid(io_master_wvalid), .io_master_wready(io_master_wready),
    .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
    .io_master_wlast(io_master_wlast),
    .io_master_bvalid(io_master_bvalid), .io_master_bready(io_master_bready),
    .io_master_bresp(io_master_bresp), .io_master_bid(io_master_bid),
    .arb_state(arb_state), .arb_owner(arb_owner)
  );

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [11:0] hs_vec();
    return {io_master_arvalid, io_master_awvalid, io_master_wvalid, io_master_rready,
            io_master_bready, m0_arready, m1_arready, m1_awready, m1_wready,
            m0_rvalid, m1_rvalid, m1_bvalid};
  endfunction

  task automatic clr();
    {m0_arvalid, m0_rready, m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_wlast, m1_bready} = '0;
    {m0_araddr, m0_arid, m0_arlen, m0_arsize, m0_arburst} = '0;
    {m1_araddr, m1_arid, m1_arlen, m1_arsize, m1_arburst} = '0;
    {m1_awaddr, m1_awid, m1_awlen, m1_awsize, m1_awburst, m1_wdata, m1_wstrb} = '0;
    {io_master_arready, io_master_rvalid, io_master_rlast, io_master_awready} = '0;
    {io_master_wready, io_master_bvalid} = '0;
    {io_master_rdata, io_master_rresp, io_master_rid, io_master_bresp, io_master_bid} = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr();
    step();
    reset = 1'b0;
  endtask

  // expected slave read data for a given address and beat
  function automatic logic [31:0] rd_f(input logic [31:0] a, input int b);
    return a ^ (32'h0101_0101 * b) ^ 32'h5A5A_0000;
  endfunction

  typedef struct {
    logic a0, a1, w1;   // m0_arvalid, m1_arvalid, m1_awvalid
    logic [1:0] st;     // expected state one cycle later
    logic own;          // expected owner
  } vec_t;

  vec_t tbl[8];

  // randomized-phase state
  int m0_left, m0_dly, m0_beat, m1_left, m1_dly, m1_beat, s_beat, cyc;
  bit m0_act, m0_ahs, m1_act, m1_wr, m1_ahs, m1_whs;
  logic [31:0] m0_addr, m1_addr, m1_data, s_addr;
  logic [7:0] m0_len, m1_len, s_len;
  logic [3:0] m0_id, m1_id, s_id, m1_strb;
  bit s_rd, s_rv, s_aw, s_w, s_bv;
  logic [1:0] s_resp, s_bresp;
  bit mfree, mlast, mown;
  logic [1:0] mkind;

  initial begin
    reset = 1'b1;
    clr();
    @(negedge clock);

    // reset with every input asserted: nothing may leak through
    {m0_arvalid, m1_arvalid, m1_awvalid, m1_wvalid, m0_rready, m1_rready, m1_bready} = '1;
    {io_master_arready, io_master_rvalid, io_master_awready, io_master_wready, io_master_bvalid} = '1;
    step();
    chk("reset_state", arb_state, 0);
    chk("reset_owner", arb_owner, 0);
    chk("reset_handshakes", hs_vec(), 0);

    tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      m0_arvalid = tbl[i].a0; m0_araddr = 32'h3000_0004;
      m1_arvalid = tbl[i].a1; m1_araddr = 32'h8000_0010;
      m1_awvalid = tbl[i].w1; m1_awaddr = 32'h8000_0020;
      io_master_arready = 1'b1; io_master_awready = 1'b1;
      #1 chk($sformatf("tbl%0d_idle_arvalid", i), io_master_arvalid, 0);
      step();
      chk($sformatf("tbl%0d_state", i), arb_state, tbl[i].st);
      chk($sformatf("tbl%0d_owner", i), arb_owner, tbl[i].own);
      chk($sformatf("tbl%0d_arvalid", i), io_master_arvalid, tbl[i].st == 2'd1);
      chk($sformatf("tbl%0d_awvalid", i), io_master_awvalid, tbl[i].st == 2'd2);
      chk($sformatf("tbl%0d_m0_arready", i), m0_arready, tbl[i].st == 2'd1 && !tbl[i].own);
      chk($sformatf("tbl%0d_m1_arready", i), m1_arready, tbl[i].st == 2'd1 && tbl[i].own);
      if (tbl[i].st == 2'd1)
        chk($sformatf("tbl%0d_araddr", i), io_master_araddr,
            tbl[i].own ? 32'h8000_0010 : 32'h3000_0004);
    end

    // IFU-only read
    do_reset();
    m0_arvalid = 1'b1; m0_araddr = 32'h3000_0000; m0_arid = 4'h2;
    step();
    chk("ifu_arvalid", io_master_arvalid, 1);
    chk("ifu_araddr", io_master_araddr, 32'h3000_0000);
    io_master_arready = 1'b1;
    step();
    m0_arvalid = 1'b0; io_master_arready = 1'b0;
    io_master_rvalid = 1'b1; io_master_rdata = 32'h0000_0413; io_master_rlast = 1'b1;
    io_master_rid = 4'h2; m0_rready = 1'b1;
    #1;
    chk("ifu_rvalid", m0_rvalid, 1);
    chk("ifu_rdata", m0_rdata, 32'h0000_0413);
    chk("ifu_rid", m0_rid, 4'h2);
    chk("ifu_m1_arready", m1_arready, 0);
    step();
    io_master_rvalid = 1'b0;
    chk("ifu_done_state", arb_state, 0);

    // LSU write with W ahead of AW, a read pending alongside (write must win)
    do_reset();
    m1_awvalid = 1'b1; m1_awaddr = 32'h8000_0100; m1_awid = 4'h5;
    m1_wvalid = 1'b1; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'b1111; m1_wlast = 1'b1;
    m1_arvalid = 1'b1; m1_araddr = 32'h8000_0200;
    step();
    chk("wr_state", arb_state, 2);
    io_master_wready = 1'b1;
    #1;
    chk("wr_wready", m1_wready, 1);
    chk("wr_awready_low", m1_awready, 0);
    chk("wr_wdata", io_master_wdata, 32'hDEAD_BEEF);
    chk("wr_wstrb", io_master_wstrb, 4'b1111);
    chk("wr_no_ar", io_master_arvalid, 0);
    step();
    m1_wvalid = 1'b0; io_master_wready = 1'b0; io_master_awready = 1'b1;
    #1 chk("wr_awready", m1_awready, 1);
    chk("wr_awaddr", io_master_awaddr, 32'h8000_0100);
    step();
    m1_awvalid = 1'b0; io_master_awready = 1'b0;
    io_master_bvalid = 1'b1; io_master_bresp = 2'b00; io_master_bid = 4'h5; m1_bready = 1'b1;
    #1;
    chk("wr_bvalid", m1_bvalid, 1);
    chk("wr_bid", m1_bid, 4'h5);
    chk("wr_still_no_ar", io_master_arvalid, 0);
    step();
    io_master_bvalid = 1'b0;
    chk("wr_done_state", arb_state, 0);
    chk("wr_bvalid_gone", m1_bvalid, 0);
    step();
    chk("wr_then_rd_state", arb_state, 1);
    chk("wr_then_rd_owner", arb_owner, 1);

    // IFU burst with an error beat; LSU waits for the whole burst
    do_reset();
    m0_arvalid = 1'b1; m0_araddr = 32'h3000_0040; m0_arlen = 8'd3;
    step();
    chk("burst_owner", arb_owner, 0);
    chk("burst_arlen", io_master_arlen, 3);
    io_master_arready = 1'b1;
    step();
    m0_arvalid = 1'b0; io_master_arready = 1'b0; m1_arvalid = 1'b1; m0_rready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      io_master_rvalid = 1'b1; io_master_rdata = 32'h100 + b;
      io_master_rresp = (b == 2) ? 2'b10 : 2'b00; io_master_rlast = (b == 3);
      #1;
      chk($sformatf("burst_rvalid%0d", b), m0_rvalid, 1);
      chk($sformatf("burst_rdata%0d", b), m0_rdata, 32'h100 + b);
      chk($sformatf("burst_rresp%0d", b), m0_rresp, (b == 2) ? 2 : 0);
      chk($sformatf("burst_m1_rvalid%0d", b), m1_rvalid, 0);
      step();
      chk($sformatf("burst_state%0d", b), arb_state, (b == 3) ? 0 : 1);
    end
    io_master_rvalid = 1'b0;
    step();
    chk("burst_next_owner", arb_owner, 1);

    // reset while the LSU has a read beat pending
    do_reset();
    m1_arvalid = 1'b1; m1_araddr = 32'h8000_0010;
    step();
    io_master_arready = 1'b1;
    step();
    m1_arvalid = 1'b0; io_master_arready = 1'b0; io_master_rvalid = 1'b1; m1_rready = 1'b1;
    #1 chk("rst_mid_rvalid", m1_rvalid, 1);
    reset = 1'b1;
    step();
    chk("rst_mid_state", arb_state, 0);
    chk("rst_mid_owner", arb_owner, 0);
    chk("rst_mid_handshakes", hs_vec(), 0);
    reset = 1'b0; io_master_rvalid = 1'b0; m1_rready = 1'b0;
    m1_arvalid = 1'b1; m1_araddr = 32'h8000_0030;
    step();
    chk("rst_after_state", arb_state, 1);
    chk("rst_after_owner", arb_owner, 1);
    chk("rst_after_arvalid", io_master_arvalid, 1);

    // randomized traffic vs. transaction-level model
    do_reset();
    m0_left = 60; m1_left = 60; m0_act = 0; m1_act = 0;
    m0_dly = $urandom_range(0, 3); m1_dly = $urandom_range(0, 3);
    s_rd = 0; s_rv = 0; s_aw = 0; s_w = 0; s_bv = 0; s_beat = 0; s_len = 0; s_id = 0; s_addr = 0;
    s_resp = 0; s_bresp = 0;
    mfree = 1; mlast = 0; mown = 0; mkind = 0; cyc = 0;
    while ((m0_left > 0 || m0_act || m1_left > 0 || m1_act) && cyc < 20000) begin
      logic was_free, r0, r1, g, cmpl;
      logic ar_hs, r_hs, aw_hs, w_hs, b_hs, m0r, m1r, m0a, m1a, m1aw, m1w, m1b;
      cyc++;
      if (!m0_act && m0_left > 0) begin
        if (m0_dly == 0) begin
          m0_act = 1; m0_ahs = 0; m0_beat = 0;
          m0_addr = 32'h3000_0000 | ($urandom_range(0, 16'h3FFF) << 2);
          m0_len = 8'($urandom_range(0, 3)); m0_id = 4'($urandom_range(0, 15));
        end else m0_dly--;
      end
      if (!m1_act && m1_left > 0) begin
        if (m1_dly == 0) begin
          m1_act = 1; m1_ahs = 0; m1_whs = 0; m1_beat = 0;
          m1_wr = $urandom_range(0, 1);
          m1_addr = 32'h8000_0000 | ($urandom_range(0, 16'h3FFF) << 2);
          m1_len = m1_wr ? 8'd0 : 8'($urandom_range(0, 2));
          m1_id = 4'($urandom_range(0, 15));
          m1_data = $urandom; m1_strb = 4'($urandom_range(1, 15));
        end else m1_dly--;
      end
      m0_arvalid = m0_act && !m0_ahs; m0_araddr = m0_addr; m0_arlen = m0_len; m0_arid = m0_id;
      m0_rready = ($urandom_range(0, 3) != 0);
      m1_arvalid = m1_act && !m1_wr && !m1_ahs;
      m1_awvalid = m1_act && m1_wr && !m1_ahs;
      m1_wvalid = m1_act && m1_wr && !m1_whs;
      m1_araddr = m1_addr; m1_arlen = m1_len; m1_arid = m1_id;
      m1_awaddr = m1_addr; m1_awlen = 8'd0; m1_awid = m1_id;
      m1_wdata = m1_data; m1_wstrb = m1_strb; m1_wlast = 1'b1;
      m1_rready = ($urandom_range(0, 3) != 0); m1_bready = ($urandom_range(0, 3) != 0);
      if (s_rd && !s_rv && $urandom_range(0, 1)) begin s_rv = 1; s_resp = 2'($urandom_range(0, 3)); end
      if (s_aw && s_w && !s_bv && $urandom_range(0, 1)) begin s_bv = 1; s_bresp = 2'($urandom_range(0, 3)); end
      io_master_arready = $urandom_range(0, 1);
      io_master_rvalid = s_rv; io_master_rdata = rd_f(s_addr, s_beat); io_master_rresp = s_resp;
      io_master_rid = s_id; io_master_rlast = (32'(s_beat) == 32'(s_len));
      io_master_awready = $urandom_range(0, 1); io_master_wready = $urandom_range(0, 1);
      io_master_bvalid = s_bv; io_master_bresp = s_bresp; io_master_bid = s_id;
      #1;
      was_free = mfree;
      if (mfree) begin
        chk("rnd_idle_state", arb_state, 0);
        chk("rnd_idle_fwd", {io_master_arvalid, io_master_awvalid, io_master_wvalid}, 0);
        r0 = m0_arvalid; r1 = m1_arvalid | m1_awvalid;
        if (r0 | r1) begin
          g = (r0 & r1) ? !mlast : r1;
          mlast = g; mown = g; mkind = (g && m1_awvalid) ? 2'd2 : 2'd1; mfree = 0;
        end
      end else begin
        chk("rnd_state", arb_state, mkind);
        chk("rnd_owner", arb_owner, mown);
        chk("rnd_nonowner_r", mown ? {m0_rvalid, m0_arready} : {m1_rvalid, m1_arready}, 0);
      end
      ar_hs = io_master_arvalid & io_master_arready;
      r_hs = io_master_rvalid & io_master_rready;
      aw_hs = io_master_awvalid & io_master_awready;
      w_hs = io_master_wvalid & io_master_wready;
      b_hs = io_master_bvalid & io_master_bready;
      m0a = m0_arvalid & m0_arready; m1a = m1_arvalid & m1_arready;
      m0r = m0_act & m0_rvalid & m0_rready; m1r = m1_act & !m1_wr & m1_rvalid & m1_rready;
      m1aw = m1_awvalid & m1_awready; m1w = m1_wvalid & m1_wready;
      m1b = m1_act & m1_wr & m1_bvalid & m1_bready;
      cmpl = 0;
      if (ar_hs) begin
        chk("rnd_araddr", io_master_araddr, mown ? m1_addr : m0_addr);
        chk("rnd_arlen", io_master_arlen, mown ? m1_len : m0_len);
        s_rd = 1; s_addr = io_master_araddr; s_len = io_master_arlen; s_id = io_master_arid; s_beat = 0;
      end
      if (m0r) begin
        chk("rnd_m0_rdata", m0_rdata, rd_f(m0_addr, m0_beat));
        chk("rnd_m0_rmeta", {m0_rresp, m0_rid, m0_rlast}, {s_resp, m0_id, 32'(m0_beat) == 32'(m0_len)});
        m0_beat++;
        if (m0_rlast) begin m0_act = 0; m0_left--; m0_dly = $urandom_range(0, 2); end
      end
      if (m1r) begin
        chk("rnd_m1_rdata", m1_rdata, rd_f(m1_addr, m1_beat));
        chk("rnd_m1_rmeta", {m1_rresp, m1_rid, m1_rlast}, {s_resp, m1_id, 32'(m1_beat) == 32'(m1_len)});
        m1_beat++;
        if (m1_rlast) begin m1_act = 0; m1_left--; m1_dly = $urandom_range(0, 2); end
      end
      if (r_hs) begin
        s_rv = 0;
        if (io_master_rlast) begin s_rd = 0; cmpl = 1; end else s_beat++;
      end
      if (aw_hs) begin
        chk("rnd_awaddr", io_master_awaddr, m1_addr);
        s_aw = 1; s_id = io_master_awid;
      end
      if (w_hs) begin
        chk("rnd_wdata", {io_master_wdata, io_master_wstrb}, {m1_data, m1_strb});
        s_w = 1;
      end
      if (m1b) begin
        chk("rnd_bresp_bid", {m1_bresp, m1_bid}, {s_bresp, m1_id});
        m1_act = 0; m1_left--; m1_dly = $urandom_range(0, 2);
      end
      if (b_hs) begin s_bv = 0; s_aw = 0; s_w = 0; cmpl = 1; end
      if (m0a) m0_ahs = 1;
      if (m1a | m1aw) m1_ahs = 1;
      if (m1w) m1_whs = 1;
      if (!was_free && cmpl) mfree = 1;
      step();
    end
    chk("rnd_all_done", 32'(m0_left + m1_left + int'(m0_act) + int'(m1_act)), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/ysyx_24090012_axi_arbiter.md
# ysyx_24090012_axi_arbiter

Two-master, one-slave AXI4 arbiter that shares the core's single `io_master` port between the instruction fetch unit (m0, read-only) and the load/store unit (m1, read/write). It serializes whole transactions: exactly one outstanding transaction exists on the slave port at any time. Grants are round-robin between masters. The block sits between IFU/LSU and the SoC bus.

## Interface
- `ID_W`, default 4: AXI ID width, forwarded unchanged.
- `clock`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `m0_ar{valid,addr,id,len,size,burst}`  in  1/32/ID_W/8/3/2: IFU read address.
- `m0_arready`  out  1: IFU read address ready.
- `m0_r{valid,data,resp,id,last}`  out  1/32/2/ID_W/1: IFU read data.
- `m0_rready`  in  1: IFU read data ready.
- `m1_ar*`, `m1_arready`, `m1_r*`, `m1_rready`: LSU read channels, same widths as m0.
- `m1_aw{valid,addr,id,len,size,burst}`  in  1/32/ID_W/8/3/2: LSU write address.
- `m1_awready`  out  1: LSU write address ready.
- `m1_w{valid,data,strb,last}`  in  1/32/4/1: LSU write data.
- `m1_wready`  out  1: LSU write data ready.
- `m1_b{valid,resp,id}`  out  1/2/ID_W: LSU write response.
- `m1_bready`  in  1: LSU write response ready.
- `io_master_*`  out/in: full AXI4 slave-facing port (AR, R, AW, W, B). Widths match the fields above.
- `arb_state`  out  2: current FSM state, for debug/perf counters.
- `arb_owner`  out  1: current owner (0 = IFU, 1 = LSU).

## Operation
- States: IDLE=0, RD=1, WR=2.
- `owner` reg: reset 0. `last` reg (last granted master): reset 0, so the LSU wins the first tie.
- IDLE: `req0 = m0_arvalid`, `req1 = m1_arvalid | m1_awvalid`.
  - Both requesting: grant `~last`.
  - One requesting: grant that master.
  - Neither: stay in IDLE.
  - On grant: `owner <= g`, `last <= g`.
  - Next state: WR if `g==1 && m1_awvalid`, else RD. LSU write beats LSU read in the same cycle.
- IDLE forwards nothing. All `io_master_*valid`, `io_master_*ready`, and all master-side ready/valid outputs are 0.
- RD: the owner's AR and R channels are wired combinationally to `io_master`. Payload fields pass unmodified, including ID.
  - All AW/W/B signals stay deasserted.
  - The non-owner sees `arready=0` and `rvalid=0`.
- WR (owner always m1): m1 AW, W, and B channels are wired to `io_master`. AW and W may complete in either order.
  - All AR/R signals stay deasserted.
  - m0 is stalled.
- Completion:
  - RD → IDLE on `io_master_rvalid & rready & rlast`.
  - WR → IDLE on `io_master_bvalid & bready`.
  - Error responses (`resp != 0`) are forwarded and still end the transaction.
  - Response IDs are not checked.
- A master that deasserts valid before its handshake is an illegal protocol use. The arbiter does not guard against it.
- Reset mid-transaction: FSM → IDLE, `owner`/`last` → 0, all outputs deasserted in the next cycle. The in-flight transaction is abandoned.

## Timing
- Arbitration latency is 1 cycle. A request visible in IDLE at cycle N appears on `io_master_*valid` at N+1.
- Grant is registered. Ownership changes only on the IDLE → RD/WR transition.
- After completion at cycle N, the FSM is in IDLE at N+1 and the next transaction reaches the slave at N+2. This is a 1-cycle bubble between back-to-back transactions.
- Burst reads (`len > 0`) hold ownership until the `rlast` beat. Fairness is per transaction, not per beat.
- Reset values: `arb_state=0`, `arb_owner=0`, every valid/ready output 0.

## Test plan
- IFU-only read: m0 `arvalid`, `araddr=0x3000_0000`, slave returns `rdata=0x0000_0413`, `rlast=1` → `io_master_arvalid` rises 1 cycle after request; `m0_rdata=0x413`; state RD→IDLE; `m1_arready` stays 0 throughout.
- Simultaneous request after reset: m0 read at `0x3000_0004`, m1 read at `0x8000_0010` → LSU granted first (`arb_owner=1`). IFU granted in the IDLE cycle after LSU `rlast`. `last` alternates 1→0.
- LSU write, W before AW: `wdata=0xDEADBEEF`, `wstrb=4'b1111` accepted while `awready=0`, then AW accepted, `bresp=0` → single B to m1, state WR→IDLE. AR is never asserted.
- Write-vs-read priority: m1 asserts `awvalid` and `arvalid` together in IDLE → state WR. The read is granted only after B completes.
- Burst and error: m0 `arlen=3`, slave returns 4 beats with `rresp=2'b10` on beat 2 → all 4 beats reach m0. Ownership is released only on beat 4 with `rlast`.
- Reset mid-read: assert `reset` while in RD with `rvalid` pending → next cycle state IDLE, `arb_owner=0`, all valids/readies 0. A new m1 request after reset is granted normally.
